// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared FSM state type, counter widths and parameter limits for tri_bus_arbiter.
package tri_bus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  localparam int HOLD_W = 4;
  localparam int TURN_W = 2;
  localparam int N_MIN = 2;
  localparam int N_MAX = 8;
  localparam int MAX_HOLD_MIN = 1;
  localparam int MAX_HOLD_MAX = (1 << HOLD_W) - 1;
  localparam int TURNAROUND_MAX = (1 << TURN_W) - 1;
endpackage

// File: rtl/tri_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search for the first set request at or after ptr.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] winner
);
  localparam int OW = $clog2(N);
  always_comb begin
    found = |req;
    winner = '0;
    // Walk offsets high to low so the smallest offset from ptr wins last.
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) winner = OW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner of a shared tri-state bus with turnaround gaps.
// Define TRI_BUS_CHK_EN to build the sticky bus-integrity checker behind err_contention.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int MAX_HOLD = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output tri   [W-1:0]         bus,
  output logic                 bus_valid,
  output logic                 err_contention
);
  localparam int OW = $clog2(N);
  state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic found, tenure_end;

  rr_picker #(.N(N)) u_pick (.req(req), .ptr(ptr_q), .found(found), .winner(winner));

  assign tenure_end = !req[owner_q] || hold_q == HOLD_W'(MAX_HOLD - 1);

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    turn_d = turn_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = DRIVE;
        gnt_d = N'(1) << winner;
        owner_d = winner;
        ptr_d = winner == OW'(N - 1) ? '0 : winner + 1'b1;
        hold_d = '0;
      end
      DRIVE: begin
        hold_d = hold_q + 1'b1;
        if (tenure_end) begin
          state_d = TURNAROUND > 0 ? TURN : IDLE;
          gnt_d = '0;
          owner_d = '0;
          hold_d = '0;
          turn_d = '0;
        end
      end
      TURN: begin
        turn_d = turn_q + 1'b1;
        state_d = turn_q == TURN_W'(TURNAROUND - 1) ? IDLE : TURN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      turn_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
    end
  end

  // One enable per requester; an ungranted requester leaves the bus floating.
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus = gnt_q[i] ? data_in[i*W +: W] : {W{1'bz}};
  end

  assign gnt = gnt_q;
  assign owner = owner_q;
  assign bus_valid = state_q == DRIVE;

`ifdef TRI_BUS_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (bus_valid && ($isunknown(bus) || !$onehot(gnt_q))) err_q <= 1'b1;
  end
  assign err_contention = err_q;
`else
  assign err_contention = 1'b0;
`endif
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed checks of grant order, tenure length, turnaround and reset.
module tb_tri_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, req0 = '0;
  logic [31:0] data_in = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [3:0] gnt, gnt0;
  logic [1:0] owner, owner0;
  tri [7:0] bus, bus0;
  logic bus_valid, bus_valid0, err, err0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(4), .TURNAROUND(1)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .owner(owner),
    .bus(bus), .bus_valid(bus_valid), .err_contention(err));

  tri_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(4), .TURNAROUND(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .data_in(data_in), .gnt(gnt0), .owner(owner0),
    .bus(bus0), .bus_valid(bus_valid0), .err_contention(err0));

`ifdef TRI_BUS_CHK_EN
  logic ext_en = 1'b0;
  assign bus = ext_en ? 8'h00 : 8'hzz;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_valid", 32'(bus_valid), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      step();
      check("lone_valid", 32'(bus_valid), 32'(c % 6 < 4));
      check("lone_gnt", 32'(gnt), c % 6 < 4 ? 1 : 0);
      if (c % 6 < 4) check("lone_bus", 32'(bus), 32'h11);
    end
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 30; c++) begin
      step();
      check("rr_valid", 32'(bus_valid), 32'(c % 6 < 4));
      check("rr_gnt", 32'(gnt), c % 6 < 4 ? 1 << ((c / 6) % 4) : 0);
      if (c % 6 < 4) begin
        check("rr_owner", 32'(owner), (c / 6) % 4);
        check("rr_bus", 32'(bus), 32'h11 * ((c / 6) % 4 + 1));
      end
    end
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    check("drop_owner", 32'(owner), 2);
    step();
    check("drop_hold2", 32'(bus_valid), 1);
    req = 4'b1010;
    step();
    check("drop_end_valid", 32'(bus_valid), 0);
    check("drop_end_gnt", 32'(gnt), 0);
    step();
    check("drop_idle", 32'(bus_valid), 0);
    step();
    check("drop_next_owner", 32'(owner), 3);
    check("drop_next_gnt", 32'(gnt), 4'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0110;
    step();
    check("mid_owner", 32'(owner), 1);
    rst = 1'b1;
    step();
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_valid", 32'(bus_valid), 0);
    check("mid_rst_owner", 32'(owner), 0);
    rst = 1'b0;
    step();
    check("mid_ptr_reset", 32'(owner), 1);
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 4'b0101;
    for (int c = 0; c < 15; c++) begin
      step();
      check("ta0_valid", 32'(bus_valid0), 32'(c % 5 < 4));
      if (c % 5 < 4) begin
        check("ta0_owner", 32'(owner0), ((c / 5) % 2) * 2);
        check("ta0_bus", 32'(bus0), (c / 5) % 2 == 1 ? 32'h33 : 32'h11);
      end
    end
    req0 = '0;
`ifdef TRI_BUS_CHK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    data_in[7:0] = 8'hFF;
    req = 4'b0001;
    ext_en = 1'b1;
    step();
    step();
    check("chk_err_set", 32'(err), 1);
    ext_en = 1'b0;
    req = '0;
    step();
    step();
    check("chk_err_sticky", 32'(err), 1);
    rst = 1'b1;
    step();
    check("chk_err_clear", 32'(err), 0);
    rst = 1'b0;
`else
    check("nochk_err", 32'(err), 0);
`endif
    check("nochk_err0", 32'(err0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
